sccb_config_sequencer: RTL and testbench

//  Walks a ROM of (register, value) pairs and drives sccb_master once per pair to configure the camera at power-up.

---
 rtl/sccb_cfg_pkg.sv | 44 ++++
 rtl/sccb_config_rom.sv | 22 ++
 rtl/sccb_config_sequencer.sv | 165 ++++++++++++++++
 tb/tb_sccb_config_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_cfg_pkg.sv
// Shared types, marker constants and ROM contents for the SCCB power-up configuration sequencer.
package sccb_cfg_pkg;

  localparam int unsigned ENTRY_W    = 16;
  localparam logic [7:0]  END_ADDR   = 8'hFF;
  localparam logic [7:0]  DELAY_ADDR = 8'hFE;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_POWERUP,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GAP,
    ST_DELAY,
    ST_DONE,
    ST_ERROR
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Table 0 is the camera bring-up list; table 1 fills every slot with a plain write (no markers).
  function automatic logic [ENTRY_W-1:0] rom_table(input int unsigned sel, input int unsigned idx);
    logic [7:0]         i8;
    logic [ENTRY_W-1:0] e;
    i8 = idx[7:0];
    e  = {END_ADDR, END_ADDR};
    if (sel == 0) begin
      case (idx)
        0:       e = {8'h12, 8'h80};
        1:       e = {DELAY_ADDR, 8'h00};
        2:       e = {8'h11, 8'h01};
        default: e = {END_ADDR, END_ADDR};
      endcase
    end else begin
      e = {1'b0, i8[6:0], ~i8};
    end
    return e;
  endfunction

endpackage

// File: rtl/sccb_config_rom.sv
// Configuration table ROM: synchronous read, one cycle from addr to {reg,val}.
module sccb_config_rom
  import sccb_cfg_pkg::*;
#(
  parameter int unsigned ROM_AW    = 8,
  parameter int unsigned TABLE_SEL = 0
) (
  input  logic               clk,
  input  logic [ROM_AW-1:0]  addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] rd_d;
  logic [ENTRY_W-1:0] rd_q;

  always_comb rd_d = rom_table(TABLE_SEL, 32'(addr));

  always_ff @(posedge clk) rd_q <= rd_d;

  assign rd_data = rd_q;

endmodule

// File: rtl/sccb_config_sequencer.sv
// Walks the configuration ROM and issues one sccb_master write per entry, with power-up,
// inter-write and marker delays, reporting done/error when the walk ends.
module sccb_config_sequencer
  import sccb_cfg_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES = 1_000_000,
  parameter int unsigned GAP_CYCLES     = 256,
  parameter int unsigned DELAY_CYCLES   = 1_000_000,
  parameter int unsigned BUSY_TIMEOUT   = 64,
  parameter int unsigned ROM_AW         = 8,
  parameter int unsigned TABLE_SEL      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_error,
  output logic [ROM_AW-1:0] cfg_index,
  output logic              sccb_start,
  output logic [7:0]        sccb_addr,
  output logic [7:0]        sccb_data,
  input  logic              sccb_busy
);

  localparam int unsigned MAX_WAIT =
    max_u(max_u(POWERUP_CYCLES, DELAY_CYCLES), max_u(GAP_CYCLES, BUSY_TIMEOUT));
  localparam int unsigned       CNT_W      = $clog2(MAX_WAIT + 1);
  localparam logic [ROM_AW-1:0] LAST_INDEX = '1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ROM_AW-1:0]  index_q, index_d;
  logic [7:0]         addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [ENTRY_W-1:0] rom_entry;

  sccb_config_rom #(
    .ROM_AW    (ROM_AW),
    .TABLE_SEL (TABLE_SEL)
  ) u_rom (
    .clk     (clk),
    .addr    (index_q),
    .rd_data (rom_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_POWERUP;
      cnt_q   <= '0;
      index_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      index_q <= index_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    index_d = index_q;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = done_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (cfg_start) begin
          state_d = ST_POWERUP;
          cnt_d   = '0;
          index_d = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_POWERUP: begin
        if (cnt_q == CNT_W'(POWERUP_CYCLES - 1)) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
          index_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // First FETCH cycle presents the address; the entry is decoded on the second.
      ST_FETCH: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_W'(1);
        end else if (rom_entry == {END_ADDR, END_ADDR}) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (rom_entry[15:8] == DELAY_ADDR) begin
          state_d = ST_DELAY;
          cnt_d   = '0;
        end else begin
          state_d = ST_ISSUE;
          addr_d  = rom_entry[15:8];
          data_d  = rom_entry[7:0];
        end
      end
      // The ISSUE cycle counts as the first cycle of the busy timeout window.
      ST_ISSUE: begin
        state_d = ST_WAIT_BUSY;
        cnt_d   = CNT_W'(1);
      end
      ST_WAIT_BUSY: begin
        if (sccb_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!sccb_busy) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end
      end
      ST_GAP, ST_DELAY: begin
        if ((state_q == ST_GAP   && cnt_q == CNT_W'(GAP_CYCLES - 1)) ||
            (state_q == ST_DELAY && cnt_q == CNT_W'(DELAY_CYCLES - 1))) begin
          if (index_q == LAST_INDEX) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FETCH;
            cnt_d   = '0;
            index_d = index_q + ROM_AW'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_busy   = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
    sccb_start = (state_q == ST_ISSUE);
  end

  assign cfg_done  = done_q;
  assign cfg_error = error_q;
  assign cfg_index = index_q;
  assign sccb_addr = addr_q;
  assign sccb_data = data_q;

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Bench for sccb_config_sequencer: randomized sccb_master timing, table-walk reference model.
module tb_sccb_config_sequencer;

  localparam int unsigned PU  = 10;
  localparam int unsigned GAP = 4;
  localparam int unsigned DLY = 20;
  localparam int unsigned BTO = 8;

  logic       clk;
  logic       rst, cfg_start, cfg_busy, cfg_done, cfg_error;
  logic [7:0] cfg_index, sccb_addr, sccb_data;
  logic       sccb_start, sccb_busy;
  logic       w_rst, w_cfg_start, w_cfg_busy, w_cfg_done, w_cfg_error;
  logic [2:0] w_cfg_index;
  logic [7:0] w_sccb_addr, w_sccb_data;
  logic       w_sccb_start, w_sccb_busy;

  logic       never_busy;
  int         checks, passes, cyc;
  int         dbl_err, hold_err;
  logic [15:0] got_q[$], w_got_q[$], exp_q[$];
  int          start_cyc[$], fall_cyc[$];

  sccb_config_sequencer #(
    .POWERUP_CYCLES (PU), .GAP_CYCLES (GAP), .DELAY_CYCLES (DLY),
    .BUSY_TIMEOUT (BTO), .ROM_AW (8), .TABLE_SEL (0)
  ) dut (
    .clk (clk), .rst (rst), .cfg_start (cfg_start), .cfg_busy (cfg_busy),
    .cfg_done (cfg_done), .cfg_error (cfg_error), .cfg_index (cfg_index),
    .sccb_start (sccb_start), .sccb_addr (sccb_addr), .sccb_data (sccb_data),
    .sccb_busy (sccb_busy)
  );

  sccb_config_sequencer #(
    .POWERUP_CYCLES (PU), .GAP_CYCLES (GAP), .DELAY_CYCLES (DLY),
    .BUSY_TIMEOUT (BTO), .ROM_AW (3), .TABLE_SEL (1)
  ) dut_w (
    .clk (clk), .rst (w_rst), .cfg_start (w_cfg_start), .cfg_busy (w_cfg_busy),
    .cfg_done (w_cfg_done), .cfg_error (w_cfg_error), .cfg_index (w_cfg_index),
    .sccb_start (w_sccb_start), .sccb_addr (w_sccb_addr), .sccb_data (w_sccb_data),
    .sccb_busy (w_sccb_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
    $fatal(1);
  end

  // sccb_master stand-ins: busy rises 1..5 cycles after start and stays high 20..40 cycles.
  initial begin : model_main
    int unsigned lat, len;
    sccb_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (sccb_start === 1'b1 && !never_busy) begin
        lat = $urandom_range(5, 1);
        len = $urandom_range(40, 20);
        repeat (lat) @(negedge clk);
        #1 sccb_busy = 1'b1;
        repeat (len) @(negedge clk);
        #1 sccb_busy = 1'b0;
      end
    end
  end

  initial begin : model_w
    int unsigned lat, len;
    w_sccb_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (w_sccb_start === 1'b1) begin
        lat = $urandom_range(5, 1);
        len = $urandom_range(40, 20);
        repeat (lat) @(negedge clk);
        #1 w_sccb_busy = 1'b1;
        repeat (len) @(negedge clk);
        #1 w_sccb_busy = 1'b0;
      end
    end
  end

  initial begin : mon_main
    logic pb, ps, pr;
    logic [15:0] pad;
    pb = 1'b0; ps = 1'b0; pr = 1'b1; pad = '0;
    forever begin
      @(negedge clk);
      if (sccb_start === 1'b1) begin
        got_q.push_back({sccb_addr, sccb_data});
        start_cyc.push_back(cyc);
      end
      if (pb && !sccb_busy) fall_cyc.push_back(cyc);
      if (ps && sccb_start) dbl_err++;
      if (!rst && !pr && pb && sccb_busy && pad !== {sccb_addr, sccb_data}) hold_err++;
      pb = sccb_busy; ps = sccb_start; pr = rst; pad = {sccb_addr, sccb_data};
    end
  end

  initial begin : mon_w
    logic pb, ps, pr;
    logic [15:0] pad;
    pb = 1'b0; ps = 1'b0; pr = 1'b1; pad = '0;
    forever begin
      @(negedge clk);
      if (w_sccb_start === 1'b1) w_got_q.push_back({w_sccb_addr, w_sccb_data});
      if (ps && w_sccb_start) dbl_err++;
      if (!w_rst && !pr && pb && w_sccb_busy && pad !== {w_sccb_addr, w_sccb_data}) hold_err++;
      pb = w_sccb_busy; ps = w_sccb_start; pr = w_rst; pad = {w_sccb_addr, w_sccb_data};
    end
  end

  function automatic logic [15:0] tbl_entry(input int sel, input int i);
    logic [7:0] b;
    b = i[7:0];
    if (sel == 0) begin
      case (i)
        0:       return 16'h1280;
        1:       return 16'hFE00;
        2:       return 16'h1101;
        default: return 16'hFFFF;
      endcase
    end
    return {1'b0, b[6:0], ~b};
  endfunction

  // Expected write list and final index from the table-walk rules.
  task automatic ref_walk(input int sel, input int depth, output int fin);
    logic [15:0] e;
    exp_q.delete();
    fin = depth - 1;
    for (int i = 0; i < depth; i++) begin
      e = tbl_entry(sel, i);
      if (e == 16'hFFFF) begin
        fin = i;
        break;
      end
      if (e[15:8] != 8'hFE) exp_q.push_back(e);
    end
  endtask

  task automatic clear_mon();
    got_q.delete(); start_cyc.delete(); fall_cyc.delete();
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); cfg_start = 1'b1;
    @(negedge clk); cfg_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cfg_busy !== 1'b1)   $display("FAIL rst_busy got=%b exp=1", cfg_busy); else passes++;
    checks++; if (cfg_done !== 1'b0)   $display("FAIL rst_done got=%b exp=0", cfg_done); else passes++;
    checks++; if (cfg_error !== 1'b0)  $display("FAIL rst_error got=%b exp=0", cfg_error); else passes++;
    checks++; if (cfg_index !== 8'd0)  $display("FAIL rst_index got=%0d exp=0", cfg_index); else passes++;
    checks++; if (sccb_start !== 1'b0) $display("FAIL rst_start got=%b exp=0", sccb_start); else passes++;
    checks++; if (sccb_addr !== 8'h00) $display("FAIL rst_addr got=%h exp=00", sccb_addr); else passes++;
    checks++; if (sccb_data !== 8'h00) $display("FAIL rst_data got=%h exp=00", sccb_data); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_table();
    int fin;
    ref_walk(0, 256, fin);
    clear_mon();
    pulse_rst();
    for (int i = 0; i < 3000 && cfg_busy; i++) @(negedge clk);
    checks++; if (cfg_busy !== 1'b0) $display("FAIL t1_busy got=%b exp=0", cfg_busy); else passes++;
    checks++; if (cfg_done !== 1'b1) $display("FAIL t1_done got=%b exp=1", cfg_done); else passes++;
    checks++; if (cfg_index !== 8'(fin)) $display("FAIL t1_index got=%0d exp=%0d", cfg_index, fin); else passes++;
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL t1_nwrites got=%0d exp=%0d", got_q.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) $display("FAIL t1_write%0d got=%h exp=%h", i, got_q[i], exp_q[i]); else passes++;
    end
    checks++;
    if (start_cyc.size() < 2 || fall_cyc.size() < 1 || (start_cyc[1] - fall_cyc[0]) < int'(GAP + DLY))
      $display("FAIL t1_delay_gap got=%0d exp>=%0d", (start_cyc.size() > 1 && fall_cyc.size() > 0) ? start_cyc[1] - fall_cyc[0] : -1, GAP + DLY);
    else passes++;
  endtask

  task automatic test_timeout();
    int s, e;
    never_busy = 1'b1;
    clear_mon();
    pulse_rst();
    for (int i = 0; i < 100 && start_cyc.size() == 0; i++) @(negedge clk);
    s = (start_cyc.size() > 0) ? start_cyc[0] : -1000;
    for (int i = 0; i < 100 && cfg_error !== 1'b1; i++) @(negedge clk);
    e = cyc;
    checks++; if (cfg_error !== 1'b1) $display("FAIL t2_error got=%b exp=1", cfg_error); else passes++;
    checks++; if (e - s != int'(BTO)) $display("FAIL t2_latency got=%0d exp=%0d", e - s, BTO); else passes++;
    checks++; if (cfg_index !== 8'd0) $display("FAIL t2_index got=%0d exp=0", cfg_index); else passes++;
    checks++; if (cfg_busy !== 1'b0)  $display("FAIL t2_busy got=%b exp=0", cfg_busy); else passes++;
    checks++; if (cfg_done !== 1'b0)  $display("FAIL t2_done got=%b exp=0", cfg_done); else passes++;
    repeat (40) @(negedge clk);
    checks++; if (start_cyc.size() != 1) $display("FAIL t2_nstarts got=%0d exp=1", start_cyc.size()); else passes++;
    never_busy = 1'b0;
  endtask

  task automatic test_restart();
    int fin;
    ref_walk(0, 256, fin);
    clear_mon();
    pulse_start();
    checks++; if (cfg_error !== 1'b0) $display("FAIL t3_err_clear got=%b exp=0", cfg_error); else passes++;
    checks++; if (cfg_busy !== 1'b1)  $display("FAIL t3_accept got=%b exp=1", cfg_busy); else passes++;
    for (int i = 0; i < 200 && sccb_busy !== 1'b1; i++) @(negedge clk);
    repeat ($urandom_range(10, 1)) @(negedge clk);
    pulse_start();
    checks++; if (cfg_busy !== 1'b1) $display("FAIL t3_ignored_busy got=%b exp=1", cfg_busy); else passes++;
    for (int i = 0; i < 3000 && cfg_busy; i++) @(negedge clk);
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL t3_nwrites got=%0d exp=%0d", got_q.size(), exp_q.size()); else passes++;
    checks++; if (cfg_done !== 1'b1) $display("FAIL t3_done got=%b exp=1", cfg_done); else passes++;
    clear_mon();
    pulse_start();
    checks++; if (cfg_done !== 1'b0)  $display("FAIL t3_done_clear got=%b exp=0", cfg_done); else passes++;
    checks++; if (cfg_index !== 8'd0) $display("FAIL t3_index_clear got=%0d exp=0", cfg_index); else passes++;
    for (int i = 0; i < 3000 && cfg_busy; i++) @(negedge clk);
    checks++; if (cfg_done !== 1'b1) $display("FAIL t3_redone got=%b exp=1", cfg_done); else passes++;
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL t3_replay_n got=%0d exp=%0d", got_q.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) $display("FAIL t3_replay%0d got=%h exp=%h", i, got_q[i], exp_q[i]); else passes++;
    end
  endtask

  task automatic test_reset_in_gap();
    int fin, rel;
    ref_walk(0, 256, fin);
    clear_mon();
    pulse_rst();
    for (int i = 0; i < 200 && sccb_busy !== 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 200 && sccb_busy !== 1'b0; i++) @(negedge clk);
    repeat ($urandom_range(2, 1)) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (cfg_busy !== 1'b1)   $display("FAIL t4_busy got=%b exp=1", cfg_busy); else passes++;
    checks++; if (cfg_index !== 8'd0)  $display("FAIL t4_index got=%0d exp=0", cfg_index); else passes++;
    checks++; if (sccb_start !== 1'b0) $display("FAIL t4_start got=%b exp=0", sccb_start); else passes++;
    checks++; if ({sccb_addr, sccb_data} !== 16'h0000) $display("FAIL t4_addr_data got=%h exp=0000", {sccb_addr, sccb_data}); else passes++;
    checks++; if ({cfg_done, cfg_error} !== 2'b00) $display("FAIL t4_flags got=%b exp=00", {cfg_done, cfg_error}); else passes++;
    rst = 1'b0;
    rel = cyc;
    clear_mon();
    for (int i = 0; i < 3000 && cfg_busy; i++) @(negedge clk);
    checks++;
    if (start_cyc.size() == 0 || start_cyc[0] - rel < int'(PU))
      $display("FAIL t4_powerup got=%0d exp>=%0d", (start_cyc.size() > 0) ? start_cyc[0] - rel : -1, PU);
    else passes++;
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL t4_nwrites got=%0d exp=%0d", got_q.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) $display("FAIL t4_write%0d got=%h exp=%h", i, got_q[i], exp_q[i]); else passes++;
    end
    checks++; if (cfg_index !== 8'(fin)) $display("FAIL t4_index_end got=%0d exp=%0d", cfg_index, fin); else passes++;
  endtask

  task automatic test_wrap();
    int fin, n;
    ref_walk(1, 8, fin);
    w_got_q.delete();
    @(negedge clk);
    w_rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5000 && w_cfg_busy; i++) @(negedge clk);
    checks++; if (w_cfg_busy !== 1'b0) $display("FAIL t5_busy got=%b exp=0", w_cfg_busy); else passes++;
    checks++; if (w_cfg_done !== 1'b1) $display("FAIL t5_done got=%b exp=1", w_cfg_done); else passes++;
    checks++; if (w_cfg_error !== 1'b0) $display("FAIL t5_error got=%b exp=0", w_cfg_error); else passes++;
    checks++; if (w_cfg_index !== 3'(fin)) $display("FAIL t5_index got=%0d exp=%0d", w_cfg_index, fin); else passes++;
    checks++; if (w_got_q.size() != exp_q.size()) $display("FAIL t5_nwrites got=%0d exp=%0d", w_got_q.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && i < w_got_q.size(); i++) begin
      checks++; if (w_got_q[i] !== exp_q[i]) $display("FAIL t5_write%0d got=%h exp=%h", i, w_got_q[i], exp_q[i]); else passes++;
    end
    n = w_got_q.size();
    repeat (60) @(negedge clk);
    checks++; if (w_cfg_index !== 3'(fin)) $display("FAIL t5_nowrap got=%0d exp=%0d", w_cfg_index, fin); else passes++;
    checks++; if (w_got_q.size() != n) $display("FAIL t5_extra got=%0d exp=%0d", w_got_q.size(), n); else passes++;
  endtask

  task automatic test_protocol();
    checks++; if (dbl_err != 0)  $display("FAIL t6_start_twice got=%0d exp=0", dbl_err); else passes++;
    checks++; if (hold_err != 0) $display("FAIL t6_hold_addr_data got=%0d exp=0", hold_err); else passes++;
  endtask

  initial begin
    rst = 1'b1; w_rst = 1'b1; cfg_start = 1'b0; w_cfg_start = 1'b0; never_busy = 1'b0;
    checks = 0; passes = 0; dbl_err = 0; hold_err = 0;
    test_reset();
    test_table();
    test_timeout();
    test_restart();
    test_reset_in_gap();
    test_wrap();
    test_protocol();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
